// File: rtl/fetch_pkg.sv
// Shared types and constants for the rysyCore instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int OPCODE_LSB = 2;
    localparam int OPCODE_MSB = 6;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC3_MSB  = 14;
    localparam int FUNC7_LSB  = 25;
    localparam int FUNC7_MSB  = 31;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// In-order instruction/PC buffer between instruction memory and decode.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          clear,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic           push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns fetch_pc, issues imem requests, buffers responses for decode.
// Optional INST_FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic        illegal
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding, out_nxt, fifo_count;
    logic [CW:0]   occupancy;
    logic          grant, byp;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]   resp_pc;
    fetch_entry_t  head, push_entry;

    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req  = (state == RUN) && !fifo_full && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // In RUN every in-flight request is from the current contiguous stream,
    // so the oldest one sits exactly 'outstanding' words behind fetch_pc.
    assign resp_pc = fetch_pc - (32'(outstanding) << 2);

`ifdef INST_FETCH_BYPASS_EN
    assign byp = (state == RUN) && fifo_empty && imem_rvalid;
`else
    assign byp = 1'b0;
`endif

    assign inst_valid = !fifo_empty || byp;
    assign fifo_pop   = inst_valid && inst_ready && !fifo_empty;
    assign fifo_push  = (state == RUN) && imem_rvalid && !redirect && !(byp && inst_ready);
    assign push_entry = '{inst: imem_rdata, pc: resp_pc};

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (redirect),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        inst    = NOP_INST;
        inst_pc = RESET_PC;
        if (!fifo_empty) begin
            inst    = head.inst;
            inst_pc = head.pc;
        end else if (byp) begin
            inst    = imem_rdata;
            inst_pc = resp_pc;
        end
    end

    assign opcode  = inst[OPCODE_MSB:OPCODE_LSB];
    assign func3   = inst[FUNC3_MSB:FUNC3_LSB];
    assign func7   = inst[FUNC7_MSB:FUNC7_LSB];
    assign illegal = inst_valid && (inst[1:0] != 2'b11);

    // Every response retires one outstanding request, kept or dropped.
    always_comb begin
        state_nxt = state;
        out_nxt   = outstanding + CW'(grant) - CW'(imem_rvalid);
        case (state)
            BOOT:  state_nxt = RUN;
            RUN:   if (redirect) state_nxt = (out_nxt != '0) ? FLUSH : RUN;
            FLUSH: state_nxt = (out_nxt != '0) ? FLUSH : RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            if (redirect)   fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (grant) fetch_pc <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: queue-based reference model, directed steps plus random traffic.
module tb_inst_fetch;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk, rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, inst_valid, inst_ready, illegal;
    logic [31:0] redirect_pc, inst, inst_pc;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    inst_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .func3(func3), .func7(func7), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] data; int due; } mreq_t;

    int vectors = 0, miscompares = 0, cyc = 0;
    // reference model: decode buffer, fresh in-flight PCs, count of responses to drop
    ent_t        buf_q[$];
    logic [31:0] inflight[$];
    int          stale;
    bit          booted, prev_redir;
    logic [31:0] ref_pc;
    mreq_t       mem_q[$];
    logic [31:0] gnt_log[$], pop_log[$];
    int          zero_hits = 0;
    // stimulus knobs
    int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, lat_min = 1, lat_extra = 0;
    bit fixed_data = 1'b0;
    logic [31:0] fixed_word = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        booted = 1'b0; stale = 0; ref_pc = RST_PC; prev_redir = 1'b0;
        buf_q.delete(); inflight.delete(); mem_q.delete();
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_req"}, imem_req, 0);
        chk({p, "_addr"}, imem_addr, RST_PC);
        chk({p, "_valid"}, inst_valid, 0);
        chk({p, "_inst"}, inst, NOP);
        chk({p, "_pc"}, inst_pc, RST_PC);
        chk({p, "_illegal"}, illegal, 0);
        chk({p, "_opcode"}, opcode, 5'b00100);
        chk({p, "_func3"}, func3, 0);
        chk({p, "_func7"}, func7, 0);
    endtask

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        if (fixed_data) return fixed_word;
        if ($urandom_range(9) != 0) w[1:0] = 2'b11;
        return w;
    endfunction

    // One cycle: drive at the negedge, compare, advance the model, return at the next negedge.
    task automatic step(input bit fr = 1'b0, input logic [31:0] fpc = 32'h0);
        bit rv, g, e_req, e_valid, byp, had, pop;
        logic [31:0] e_inst, e_pc, pc;
        mreq_t m;
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        e_req = booted && (stale == 0) && (inflight.size() + buf_q.size() < DEPTH);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_q[0].data : $urandom;
        imem_gnt    = e_req && ($urandom_range(99) < gnt_pct);
        redirect    = fr || (booted && !prev_redir && ($urandom_range(99) < redir_pct));
        redirect_pc = fr ? fpc : $urandom;
        inst_ready  = ($urandom_range(99) < rdy_pct);
        #1;
        g   = e_req && imem_gnt;
        had = buf_q.size() > 0;
`ifdef INST_FETCH_BYPASS_EN
        byp = booted && (stale == 0) && !had && rv;
`else
        byp = 1'b0;
`endif
        e_valid = had || byp;
        e_inst  = had ? buf_q[0].inst : (byp ? imem_rdata : 32'h0);
        e_pc    = had ? buf_q[0].pc : (byp ? inflight[0] : 32'h0);
        chk("req", imem_req, e_req);
        chk("addr", imem_addr, ref_pc);
        chk("valid", inst_valid, e_valid);
        chk("illegal", illegal, e_valid && (e_inst[1:0] != 2'b11));
        if (e_valid) begin
            chk("inst", inst, e_inst);
            chk("inst_pc", inst_pc, e_pc);
            chk("opcode", opcode, e_inst[6:2]);
            chk("func3", func3, e_inst[14:12]);
            chk("func7", func7, e_inst[31:25]);
            if (e_inst == 32'h0) begin
                zero_hits++;
                chk("zero_illegal", illegal, 1);
                chk("zero_opcode", opcode, 0);
            end
        end
        pop = e_valid && inst_ready;
        if (g)   gnt_log.push_back(ref_pc);
        if (pop) pop_log.push_back(e_pc);
        if (!booted) begin
            booted = 1'b1;
        end else if (redirect) begin
            stale = stale + inflight.size() + int'(g) - int'(rv);
            inflight.delete();
            buf_q.delete();
            ref_pc = redirect_pc & ~32'h3;
        end else begin
            if (pop && had) void'(buf_q.pop_front());
            if (rv) begin
                if (stale > 0) stale--;
                else begin
                    pc = inflight.pop_front();
                    if (!(byp && inst_ready)) buf_q.push_back('{inst: imem_rdata, pc: pc});
                end
            end
            if (g) begin
                inflight.push_back(ref_pc);
                ref_pc = ref_pc + 32'd4;
            end
        end
        if (rv) void'(mem_q.pop_front());
        if (g) begin
            m.data = gen_word();
            m.due  = cyc + lat_min + int'($urandom_range(lat_extra));
            mem_q.push_back(m);
        end
        prev_redir = redirect;
        cyc++;
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle; outputs must change with no clock edge.
    task automatic async_reset(input string p);
        #2;
        rst = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
        #1;
        check_reset_outputs(p);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int hits;
        rst = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect = 0; redirect_pc = 0; inst_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;

        // straight-line fetch with 1-cycle memory
        fixed_data = 1'b1; fixed_word = 32'h0050_0093;
        gnt_log.delete(); pop_log.delete();
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_addr%0d", i), gnt_log.size() > i ? gnt_log[i] : 32'hDEAD_BEEF, 32'(i * 4));
            chk($sformatf("t1_pc%0d", i), pop_log.size() > i ? pop_log[i] : 32'hDEAD_BEEF, 32'(i * 4));
        end

        // decode stalled: buffer fills, requests stop
        async_reset("rst1");
        rdy_pct = 0;
        gnt_log.delete(); pop_log.delete();
        repeat (8) step();
        chk("t2_ngnt", gnt_log.size(), DEPTH);
        chk("t2_req_idle", imem_req, 0);
        gnt_log.delete(); pop_log.delete();
        rdy_pct = 100; step();
        rdy_pct = 0; repeat (4) step();
        chk("t2_pulse_pops", pop_log.size(), 1);
        chk("t2_pulse_gnts", gnt_log.size(), 1);
        chk("t2_full_valid", inst_valid, 1);
        async_reset("rst_full");

        // redirect with two responses in flight
        rdy_pct = 100; lat_min = 4;
        step(); step(); step();
        step(1'b1, 32'h0000_0103);
        gnt_log.delete(); pop_log.delete();
        repeat (14) step();
        chk("t3_addr", gnt_log.size() > 0 ? gnt_log[0] : 32'hDEAD_BEEF, 32'h100);
        chk("t3_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

        // second redirect while flushing
        async_reset("rst2");
        step(); step(); step();
        step(1'b1, 32'h0000_0100);
        step();
        step(1'b1, 32'h0000_0200);
        gnt_log.delete(); pop_log.delete();
        repeat (14) step();
        chk("t4_addr", gnt_log.size() > 0 ? gnt_log[0] : 32'hDEAD_BEEF, 32'h200);
        chk("t4_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h200);
        hits = 0;
        foreach (pop_log[i]) if (pop_log[i][31:8] == 24'h1) hits++;
        chk("t4_no_0x100", hits, 0);

        // fetch_pc wrap
        lat_min = 1;
        step(1'b1, 32'hFFFF_FFFF);
        gnt_log.delete();
        for (int i = 0; i < 20 && gnt_log.size() < 2; i++) step();
        chk("t5_addr0", gnt_log.size() > 0 ? gnt_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("t5_wrap", gnt_log.size() > 1 ? gnt_log[1] : 32'hDEAD_BEEF, 32'h0);

        // all-zero instruction word
        fixed_word = 32'h0;
        step(1'b1, 32'h0000_0040);
        zero_hits = 0;
        repeat (10) step();
        chk("t6_zero_seen", zero_hits > 0, 1);

        // random traffic
        fixed_data = 1'b0; lat_min = 1; lat_extra = 2;
        gnt_pct = 70; rdy_pct = 60; redir_pct = 4;
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
